// File: rtl/mult_div.sv
// Sequential signed multiply/divide unit producing MIPS HI/LO results.
// One shift-add or restoring-division step per clock, WIDTH steps per operation.
module mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             op_q;
    logic             neg_a;
    logic             neg_b;
    // mag_q: multiplicand (mult) or divisor (div); work_lo: multiplier or dividend/quotient
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH:0]     div_diff_c;
    logic [WIDTH-1:0]   step_hi_c;
    logic [WIDTH-1:0]   step_lo_c;
    logic [2*WIDTH-1:0] product_c;
    logic [WIDTH-1:0]   res_hi_c;
    logic [WIDTH-1:0]   res_lo_c;

    // Single iteration step plus final sign correction of the result.
    always_comb begin
        a_mag_c     = a[WIDTH-1] ? WIDTH'(0) - a : a;
        b_mag_c     = b[WIDTH-1] ? WIDTH'(0) - b : b;
        mul_sum_c   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_q} : (WIDTH+1)'(0));
        div_shift_c = {work_hi, work_lo[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, mag_q};
        step_hi_c   = work_hi;
        step_lo_c   = work_lo;
        product_c   = '0;
        res_hi_c    = '0;
        res_lo_c    = '0;
        if (!op_q) begin
            step_hi_c = mul_sum_c[WIDTH:1];
            step_lo_c = {mul_sum_c[0], work_lo[WIDTH-1:1]};
            product_c = {step_hi_c, step_lo_c};
            if (neg_a ^ neg_b) begin
                product_c = (2*WIDTH)'(0) - product_c;
            end
            res_hi_c = product_c[2*WIDTH-1:WIDTH];
            res_lo_c = product_c[WIDTH-1:0];
        end else begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            step_hi_c = div_diff_c[WIDTH] ? div_shift_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
            step_lo_c = {work_lo[WIDTH-2:0], ~div_diff_c[WIDTH]};
            res_lo_c  = (neg_a ^ neg_b) ? WIDTH'(0) - step_lo_c : step_lo_c;
            res_hi_c  = neg_a ? WIDTH'(0) - step_hi_c : step_hi_c;
        end
    end

    // Control FSM with registered handshake and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            op_q     <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            mag_q    <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_a   <= a[WIDTH-1];
                        neg_b   <= b[WIDTH-1];
                        counter <= '0;
                        work_hi <= '0;
                        mag_q   <= op ? b_mag_c : a_mag_c;
                        work_lo <= op ? a_mag_c : b_mag_c;
                        if (op && (b == '0)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work_hi <= step_hi_c;
                    work_lo <= step_lo_c;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        hi    <= res_hi_c;
                        lo    <= res_lo_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed table-driven bench for mult_div: signed mult/div results, handshake
// timing, divide-by-zero, ignored starts and mid-operation reset.
module tb_mult_div;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    mult_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one start for a single edge, then scramble operands (don't-care).
    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = ~o;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
    endtask

    // Called just after the start edge (or later, with fewer busy cycles left).
    task automatic finish_op(input string name, input int exp_busy,
                             input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int busy_cycles = 0;
        int overlap     = 0;
        for (int i = 0; i < exp_busy; i++) begin
            if (busy && !done) busy_cycles++;
            if (busy && done) overlap++;
            tick();
        end
        check({name, " busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
        check({name, " busy_done_overlap"}, 64'(overlap), 64'd0);
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " busy_at_done"}, {63'd0, busy}, 64'd0);
        check({name, " div_zero"}, {63'd0, div_zero}, 64'd0);
        check({name, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({name, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        tick();
        check({name, " done_pulse_end"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"mul_7_m3",       1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"mul_minmin",     1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2]  = '{"div_m7_2",       1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"div_overflow",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{"mul_m1_m1",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[5]  = '{"mul_maxmax",     1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{"mul_zero",       1'b0, 32'd0,          32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{"div_7_m2",       1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{"div_m7_m2",      1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[9]  = '{"div_100_7",      1'b1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{"div_min_2",      1'b1, 32'h8000_0000,  32'd2,         32'h0000_0000, 32'hC000_0000};
        vecs[11] = '{"div_5_7",        1'b1, 32'd5,          32'd7,         32'h0000_0005, 32'h0000_0000};
        vecs[12] = '{"mul_min_1",      1'b0, 32'h8000_0000,  32'd1,         32'hFFFF_FFFF, 32'h8000_0000};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_outputs", {61'd0, busy, done, div_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op(vecs[i].name, 32, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Divide by zero keeps HI/LO from the previous op (629/18 -> q=0x22, r=0x11).
        launch(1'b1, 32'd629, 32'd18);
        finish_op("preload", 32, 32'h11, 32'h22);
        launch(1'b1, 32'd100, 32'd0);
        check("dz_done", {62'd0, done, div_zero}, 64'd3);
        check("dz_busy", {63'd0, busy}, 64'd0);
        check("dz_hilo", {hi, lo}, {32'h11, 32'h22});
        tick();
        check("dz_after", {61'd0, busy, done, div_zero}, 64'd0);
        check("dz_hilo_after", {hi, lo}, {32'h11, 32'h22});

        // Start pulsed during RUN is ignored.
        launch(1'b0, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        tick();
        start = 1'b0;
        finish_op("ignored_start", 27, 32'd0, 32'd15);

        // Start held in the DONE cycle is not accepted.
        launch(1'b0, 32'd2, 32'd3);
        for (int i = 0; i < 32; i++) tick();
        check("done_cycle", {63'd0, done}, 64'd1);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd4;
        b     = 32'd4;
        tick();
        start = 1'b0;
        check("start_in_done_ignored", {62'd0, busy, done}, 64'd0);
        tick();
        check("still_idle", {63'd0, busy}, 64'd0);
        check("done_start_hilo", {hi, lo}, {32'd0, 32'd6});

        // Reset in the middle of RUN aborts and clears HI/LO.
        launch(1'b0, 32'd3, 32'd5);
        for (int i = 0; i < 9; i++) tick();
        check("run_busy_before_reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        launch(1'b0, 32'd6, 32'd7);
        finish_op("after_abort", 32, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
